// File: rtl/byte_ram_if.sv
// byte_ram_if
//   Byte-serial RAM bus between the core's load/store/fetch unit (master)
//   and the memory-side responder (slave), plus the tx drain handshake and
//   the halt flag.
//   master drives : ram_addr, ram_writing, ram_data, io_tx_ready
//   slave drives  : ram_loaded_data, io_full, io_tx_data, io_tx_valid, halt
interface byte_ram_if;
    logic [31:0] ram_addr;
    logic        ram_writing;
    logic [7:0]  ram_data;
    logic [7:0]  ram_loaded_data;
    logic        io_full;
    logic [7:0]  io_tx_data;
    logic        io_tx_valid;
    logic        io_tx_ready;
    logic        halt;

    modport master (
        output ram_addr, ram_writing, ram_data, io_tx_ready,
        input  ram_loaded_data, io_full, io_tx_data, io_tx_valid, halt
    );

    modport slave (
        input  ram_addr, ram_writing, ram_data, io_tx_ready,
        output ram_loaded_data, io_full, io_tx_data, io_tx_valid, halt
    );
endinterface

// File: rtl/byte_ram_responder.sv
// byte_ram_responder
//   Memory-side responder for the byte-serial RAM bus. Every cycle is a
//   request; each one is answered one cycle later on ram_loaded_data.
//   Holds a 2^ADDR_WIDTH byte unified RAM and a small I/O window:
//     IO_BASE+0 : TX   - writes push a byte into the tx FIFO
//     IO_BASE+4 : END  - writes set the sticky halt flag
//     IO_BASE+8 : STAT - only when BYTE_RAM_IO_STATUS_EN is defined:
//                        reads {overflow, count}, writes clear overflow
//   Optional feature macro: BYTE_RAM_IO_STATUS_EN (STAT is unmapped when
//   it is not defined).
// Ports
//   i_clk  : clock, all state on posedge
//   i_rst  : asynchronous active-high reset (RAM contents are kept)
//   bus    : byte_ram_if.slave (request in, loaded byte / tx FIFO / halt out)
module byte_ram_responder #(
    parameter int          ADDR_WIDTH = 17,
    parameter logic [31:0] IO_BASE    = 32'h0003_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    byte_ram_if.slave  bus
);

    localparam int          PTR_W     = $clog2(FIFO_DEPTH);
    localparam int          CNT_W     = PTR_W + 1;
    localparam int          RAM_BYTES = 1 << ADDR_WIDTH;
    localparam logic [31:0] TX_ADDR   = IO_BASE;
    localparam logic [31:0] END_ADDR  = IO_BASE + 32'd4;
    localparam logic [31:0] STAT_ADDR = IO_BASE + 32'd8;

    // Storage (no reset: RAM survives rst, FIFO slots are gated by count)
    logic [7:0]       r_mem  [RAM_BYTES];
    logic [7:0]       r_fifo [FIFO_DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             r_full;
    logic             r_halt;
    logic [7:0]       r_loaded;

    logic                  w_is_ram;
    logic                  w_is_tx;
    logic                  w_is_end;
    logic [ADDR_WIDTH-1:0] w_ram_idx;
    logic                  w_ram_wr;
    logic                  w_push_req;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_fifo_full;
    logic                  w_ovf_set;
    logic                  w_ovf_clr;
    logic [CNT_W-1:0]      w_next_count;
    logic [7:0]            w_rd_next;

    // Region decode: RAM is everything below 2^ADDR_WIDTH
    assign w_is_ram   = (bus.ram_addr >> ADDR_WIDTH) == 32'd0;
    assign w_is_tx    = bus.ram_addr == TX_ADDR;
    assign w_is_end   = bus.ram_addr == END_ADDR;
    assign w_ram_idx  = bus.ram_addr[ADDR_WIDTH-1:0];
    assign w_ram_wr   = w_is_ram && bus.ram_writing;
    assign w_push_req = w_is_tx && bus.ram_writing;

    assign w_fifo_full = r_count == CNT_W'(FIFO_DEPTH);
    assign w_pop       = (r_count != CNT_W'(0)) && bus.io_tx_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_push      = w_push_req && (!w_fifo_full || w_pop);
    assign w_ovf_set   = w_push_req && w_fifo_full && !w_pop;

`ifdef BYTE_RAM_IO_STATUS_EN
    logic       w_is_stat;
    logic [7:0] w_stat_byte;
    assign w_is_stat   = bus.ram_addr == STAT_ADDR;
    assign w_ovf_clr   = w_is_stat && bus.ram_writing;
    assign w_stat_byte = {r_overflow, 7'(r_count)};
`else
    // Overflow is tracked but has no reader without the status register
    logic w_unused_ovf;
    assign w_unused_ovf = r_overflow;
    assign w_ovf_clr    = 1'b0;
`endif

    // Occupancy after this edge's push/pop
    always_comb begin
        w_next_count = r_count;
        case ({w_push, w_pop})
            2'b10:   w_next_count = r_count + CNT_W'(1);
            2'b01:   w_next_count = r_count - CNT_W'(1);
            default: w_next_count = r_count;
        endcase
    end

    // Next loaded byte: RAM writes are written through without reading the old byte
    always_comb begin
        w_rd_next = 8'h00;
        if (w_is_ram) begin
            if (bus.ram_writing) begin
                w_rd_next = bus.ram_data;
            end else begin
                w_rd_next = r_mem[w_ram_idx];
            end
        end
`ifdef BYTE_RAM_IO_STATUS_EN
        else if (w_is_stat && !bus.ram_writing) begin
            w_rd_next = w_stat_byte;
        end
`endif
        else begin
            w_rd_next = 8'h00;
        end
    end

    // RAM byte write
    always_ff @(posedge i_clk) begin
        if (w_ram_wr) begin
            r_mem[w_ram_idx] <= bus.ram_data;
        end
    end

    // FIFO slot write at the tail
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= bus.ram_data;
        end
    end

    // Control state: FIFO pointers/count, flags and the registered read byte
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr   <= PTR_W'(0);
            r_rd_ptr   <= PTR_W'(0);
            r_count    <= CNT_W'(0);
            r_overflow <= 1'b0;
            r_full     <= 1'b0;
            r_halt     <= 1'b0;
            r_loaded   <= 8'h00;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_next_count;
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end
            // One spare slot absorbs the write issued while the requester reacts
            r_full   <= w_next_count >= CNT_W'(FIFO_DEPTH - 1);
            if (w_is_end && bus.ram_writing) begin
                r_halt <= 1'b1;
            end
            r_loaded <= w_rd_next;
        end
    end

    assign bus.ram_loaded_data = r_loaded;
    assign bus.io_full         = r_full;
    assign bus.halt            = r_halt;
    assign bus.io_tx_valid     = r_count != CNT_W'(0);
    assign bus.io_tx_data      = (r_count != CNT_W'(0)) ? r_fifo[r_rd_ptr] : 8'h00;

endmodule

// File: tb/tb_byte_ram_responder.sv
module tb_byte_ram_responder;
    localparam int          AW  = 17;
    localparam logic [31:0] IOB = 32'h0003_0000;
    localparam int          D   = 8;

`ifdef BYTE_RAM_IO_STATUS_EN
    localparam logic [7:0] STAT_FULL = 8'h88;
    localparam logic [7:0] STAT_CLR  = 8'h08;
`else
    localparam logic [7:0] STAT_FULL = 8'h00;
    localparam logic [7:0] STAT_CLR  = 8'h00;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    byte_ram_if bus();

    byte_ram_responder #(.ADDR_WIDTH(AW), .IO_BASE(IOB), .FIFO_DEPTH(D)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: sparse memory, FIFO queue, flags
    logic [7:0] m_mem [int];
    logic [7:0] m_q [$];
    logic       m_halt = 1'b0;
    logic       m_ovf  = 1'b0;
    logic [7:0] m_loaded = 8'h00;
    logic       m_loaded_known = 1'b1;
    logic [7:0] seen [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        if (m_loaded_known) chk("ram_loaded_data", bus.ram_loaded_data, m_loaded);
        chk("io_full", bus.io_full, m_q.size() >= D - 1);
        chk("io_tx_valid", bus.io_tx_valid, m_q.size() != 0);
        chk("io_tx_data", bus.io_tx_data, (m_q.size() != 0) ? m_q[0] : 8'h00);
        chk("halt", bus.halt, m_halt);
    endtask

    task automatic model_edge(input logic [31:0] a, input logic wr, input logic [7:0] d, input logic rdy);
        logic pop;
        pop = (m_q.size() != 0) && rdy;
        m_loaded_known = 1'b1;
        if (a < (32'h1 << AW)) begin
            if (wr) begin
                m_mem[int'(a)] = d;
                m_loaded = d;
            end else if (m_mem.exists(int'(a))) begin
                m_loaded = m_mem[int'(a)];
            end else begin
                m_loaded_known = 1'b0;
            end
        end else if (a == IOB + 32'd8 && !wr) begin
`ifdef BYTE_RAM_IO_STATUS_EN
            m_loaded = {m_ovf, 7'(m_q.size())};
`else
            m_loaded = 8'h00;
`endif
        end else begin
            m_loaded = 8'h00;
        end
        if (pop) void'(m_q.pop_front());
        if (wr && a == IOB) begin
            if (m_q.size() < D) m_q.push_back(d);
            else m_ovf = 1'b1;
        end
        if (wr && a == IOB + 32'd4) m_halt = 1'b1;
`ifdef BYTE_RAM_IO_STATUS_EN
        if (wr && a == IOB + 32'd8) m_ovf = 1'b0;
`endif
    endtask

    task automatic step(input logic [31:0] a, input logic wr, input logic [7:0] d, input logic rdy);
        bus.ram_addr    = a;
        bus.ram_writing = wr;
        bus.ram_data    = d;
        bus.io_tx_ready = rdy;
        @(posedge clk);
        model_edge(a, wr, d, rdy);
        #1;
        compare_all();
    endtask

    task automatic drain(input int n);
        seen.delete();
        for (int i = 0; i < n; i++) begin
            if (bus.io_tx_valid) seen.push_back(bus.io_tx_data);
            step(32'h0002_0000, 1'b0, 8'h00, 1'b1);
        end
    endtask

    task automatic mid_reset();
        #3 rst = 1'b1;
        #1;
        m_q.delete();
        m_halt = 1'b0;
        m_ovf  = 1'b0;
        m_loaded = 8'h00;
        m_loaded_known = 1'b1;
        compare_all();
        chk("halt cleared by rst", bus.halt, 1'b0);
        chk("tx_valid cleared by rst", bus.io_tx_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.ram_addr    = 32'h0;
        bus.ram_writing = 1'b0;
        bus.ram_data    = 8'h00;
        bus.io_tx_ready = 1'b0;
        #12;
        compare_all();
        chk("reset loaded", bus.ram_loaded_data, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // RAM write-through and read-back
        step(32'h0000_0010, 1'b1, 8'hA5, 1'b0);
        step(32'h0000_0010, 1'b0, 8'h00, 1'b0);
        chk("read 0x10", bus.ram_loaded_data, 8'hA5);
        step(32'h0001_FFFF, 1'b1, 8'h3C, 1'b0);
        step(32'h0001_FFFF, 1'b0, 8'h00, 1'b0);
        chk("read 0x1FFFF", bus.ram_loaded_data, 8'h3C);
        step(32'h0002_0000, 1'b0, 8'h00, 1'b0);
        chk("read unmapped", bus.ram_loaded_data, 8'h00);

        // Unmapped write ignored, TX/END reads return zero
        step(32'h0002_0000, 1'b1, 8'h77, 1'b0);
        step(IOB, 1'b0, 8'h00, 1'b0);
        step(IOB + 32'd4, 1'b0, 8'h00, 1'b0);
        chk("END read keeps halt low", bus.halt, 1'b0);

        // Fill tx FIFO: full flag after 7th, 8th accepted, 9th dropped
        for (int i = 0; i < 9; i++) begin
            step(IOB, 1'b1, 8'(8'h41 + i), 1'b0);
            if (i == 5) chk("io_full after 6", bus.io_full, 1'b0);
            if (i == 6) chk("io_full after 7", bus.io_full, 1'b1);
        end

        // Status register (reads zero when the feature is not built)
        step(IOB + 32'd8, 1'b0, 8'h00, 1'b0);
        chk("stat after overflow", bus.ram_loaded_data, STAT_FULL);
        step(IOB + 32'd8, 1'b1, 8'hFF, 1'b0);
        step(IOB + 32'd8, 1'b0, 8'h00, 1'b0);
        chk("stat after clear", bus.ram_loaded_data, STAT_CLR);

        // Drain in order; valid drops after the 8th pop
        drain(8);
        chk("drain count", seen.size(), 8);
        for (int i = 0; i < 8; i++) chk("drain order", seen[i], 8'h41 + i);
        chk("valid after drain", bus.io_tx_valid, 1'b0);
        step(32'h0002_0000, 1'b0, 8'h00, 1'b1);
        step(32'h0002_0000, 1'b0, 8'h00, 1'b1);

        // Full FIFO with simultaneous pop and push
        for (int i = 0; i < 8; i++) step(IOB, 1'b1, 8'(8'h51 + i), 1'b0);
        step(IOB, 1'b1, 8'h50, 1'b1);
        chk("full kept on push+pop", bus.io_full, 1'b1);
        drain(8);
        chk("push+pop count", seen.size(), 8);
        chk("push+pop first", seen[0], 8'h52);
        chk("push+pop last", seen[7], 8'h50);

        // Halt, then async reset with bytes queued
        step(IOB + 32'd4, 1'b1, 8'h99, 1'b0);
        chk("halt set", bus.halt, 1'b1);
        step(IOB, 1'b1, 8'h61, 1'b0);
        step(IOB, 1'b1, 8'h62, 1'b0);
        mid_reset();
        step(32'h0000_0010, 1'b0, 8'h00, 1'b0);
        chk("RAM kept over rst", bus.ram_loaded_data, 8'hA5);
        chk("halt stays low", bus.halt, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
